// File: rtl/ten_bit_adder.sv
// Registered ripple-carry adder with one-cycle latency and a synchronous active-high reset.
// Optional carry-out and signed-overflow flag outputs are enabled by defining TEN_BIT_ADDER_FLAGS_EN.
module ten_bit_adder #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
`ifdef TEN_BIT_ADDER_FLAGS_EN
    output logic             Cout,
    output logic             Overflow,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carry_d;
    logic             ovf_d;
    logic             vld_q;

    // Ripple chain: the carry travels bit by bit from a tied-off carry-in.
    always_comb begin
        logic c;
        c       = 1'b0;
        sum_d   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum_d[i] = A[i] ^ B[i] ^ c;
            c        = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        carry_d = c;
        ovf_d   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_d[WIDTH-1] != A[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                sum_q <= sum_d;
            end
        end
    end

    assign Sum       = sum_q;
    assign out_valid = vld_q;

`ifdef TEN_BIT_ADDER_FLAGS_EN
    logic cout_q, ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (in_valid) begin
            cout_q <= carry_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Cout     = cout_q;
    assign Overflow = ovf_q;
`else
    logic unused_flags;
    assign unused_flags = carry_d ^ ovf_d;
`endif

endmodule

// File: tb/tb_ten_bit_adder.sv
// Self-checking bench for ten_bit_adder: directed vectors plus randomized traffic
// compared against an arithmetic reference model.
module tb_ten_bit_adder;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a, b;
    logic         in_valid;
    logic [W-1:0] sum;
    logic         out_valid;
`ifdef TEN_BIT_ADDER_FLAGS_EN
    logic         cout, ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [W-1:0] m_sum;
    logic         m_vld, m_cout, m_ovf;

    ten_bit_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (a),
        .B        (b),
        .in_valid (in_valid),
        .Sum      (sum),
`ifdef TEN_BIT_ADDER_FLAGS_EN
        .Cout     (cout),
        .Overflow (ovf),
`endif
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    task automatic model(input logic r, input logic v, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        int total, ssum;
        if (r) begin
            m_sum = '0; m_vld = 0; m_cout = 0; m_ovf = 0;
        end else begin
            m_vld = v;
            if (v) begin
                total  = int'(x) + int'(y);
                m_sum  = W'(total % (1 << W));
                m_cout = (total >= (1 << W));
                ssum   = to_signed(x) + to_signed(y);
                m_ovf  = (ssum > (1 << (W-1)) - 1) || (ssum < -(1 << (W-1)));
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic v,
                        input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        reset = r; in_valid = v; a = x; b = y;
        @(posedge clk);
        model(r, v, x, y);
        #1;
        chk({tag, ".sum"}, 32'(sum), 32'(m_sum));
        chk({tag, ".vld"}, 32'(out_valid), 32'(m_vld));
`ifdef TEN_BIT_ADDER_FLAGS_EN
        chk({tag, ".cout"}, 32'(cout), 32'(m_cout));
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
`endif
    endtask

    initial begin
        logic [W-1:0] ra, rb, sum_ab;
        reset = 1; in_valid = 0; a = '0; b = '0;
        m_sum = '0; m_vld = 0; m_cout = 0; m_ovf = 0;

        step("rst0", 1, 0, 10'h000, 10'h000);
        step("rst1", 1, 1, 10'h155, 10'h0AA);
        step("one", 0, 1, 10'h001, 10'h000);
        chk("one.lit", 32'(sum), 32'h001);
        step("allones", 0, 1, 10'h01F, 10'h3E0);
        chk("allones.lit", 32'(sum), 32'h3FF);
        step("dbl1f", 0, 1, 10'h01F, 10'h01F);
        chk("dbl1f.lit", 32'(sum), 32'h03E);
        step("wrap", 0, 1, 10'h3FF, 10'h001);
        chk("wrap.lit", 32'(sum), 32'h000);
`ifdef TEN_BIT_ADDER_FLAGS_EN
        chk("wrap.cout.lit", 32'(cout), 32'h1);
`endif
        step("max0", 0, 1, 10'h3FF, 10'h000);
        step("ovfp", 0, 1, 10'h1FF, 10'h001);
        chk("ovfp.lit", 32'(sum), 32'h200);
`ifdef TEN_BIT_ADDER_FLAGS_EN
        chk("ovfp.ovf.lit", 32'(ovf), 32'h1);
`endif
        step("ovfn", 0, 1, 10'h200, 10'h200);
        step("load3ff", 0, 1, 10'h3FF, 10'h000);
        step("hold0", 0, 0, 10'h123, 10'h045);
        step("hold1", 0, 0, 10'h3FF, 10'h3FF);
        step("hold2", 0, 0, 10'h200, 10'h1FF);
        chk("hold.lit", 32'(sum), 32'h3FF);
        step("rstprio", 1, 1, 10'h0F0, 10'h00F);
        chk("rstprio.lit", 32'(sum), 32'h000);
        step("postrst", 0, 1, 10'h002, 10'h003);

        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), ra, rb);
            if (!reset && in_valid) begin
                sum_ab = sum;
                step("swap", 0, 1, rb, ra);
                chk("swap.eq", 32'(sum), 32'(sum_ab));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
